// File: rtl/tile_fetch_pkg.sv
// Shared types and sizing helpers for the strided tile fetch stream.
package tile_fetch_pkg;

    localparam int unsigned PKG_DATA_W     = 16;
    localparam int unsigned PKG_LANES      = 4;
    localparam int unsigned PKG_FIFO_DEPTH = 8;

    // Width needed to count 0..depth inclusive.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $unsigned($clog2(depth + 1));
    endfunction

    localparam int unsigned CREDIT_W = credit_w(PKG_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [PKG_LANES*PKG_DATA_W-1:0] data;
        logic                            row_last;
        logic                            last;
    } beat_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// First-word-fall-through skid FIFO of output beats; head is visible while not empty.
module fetch_skid_fifo
    import tile_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = PKG_FIFO_DEPTH,
    parameter int unsigned CNT_W = credit_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  beat_t            push_beat_i,
    input  logic             pop_i,
    output beat_t            head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    beat_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[PTR_W'(i)] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_beat_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Upstream credit logic must never push into a full FIFO without a pop.
    assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/tile_fetch_stream.sv
// Streams a strided 2-D tile from a multi-lane read port to the array feeder.
module tile_fetch_stream
    import tile_fetch_pkg::*;
#(
    parameter int unsigned DATA_W     = PKG_DATA_W,
    parameter int unsigned LANES      = PKG_LANES,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DIM_W      = 10,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = PKG_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       cfg_base,
    input  logic [DIM_W-1:0]        cfg_rows,
    input  logic [DIM_W-1:0]        cfg_cols,
    input  logic [ADDR_W-1:0]       cfg_stride,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [LANES*DATA_W-1:0] rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_row_last,
    output logic                    out_last
);

    localparam int unsigned CNT_W = credit_w(FIFO_DEPTH);

    fetch_state_t      state_q, state_d;
    logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
    logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] stride_q, stride_d, row_base_q, row_base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d, done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0]  credit_q, credit_d;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_rl_q, pipe_last_q;
    logic              issue_row_last, issue_last, pop;
    beat_t             push_beat, head;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Position flags of the word currently presented on rd_addr.
    assign issue_row_last = (col_q == cols_q - DIM_W'(1));
    assign issue_last     = issue_row_last && (row_q == rows_q - DIM_W'(1));
    assign pop            = !fifo_empty && out_ready;

    // Next-state, address walk and credit accounting; rd_en is decided one cycle ahead.
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        stride_d   = stride_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        credit_d   = credit_q + CNT_W'(rd_en_q) - CNT_W'(pop);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_rows == '0 || cfg_cols == '0) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d    = ISSUE;
                        rows_d     = cfg_rows;
                        cols_d     = cfg_cols;
                        stride_d   = cfg_stride;
                        row_d      = '0;
                        col_d      = '0;
                        row_base_d = cfg_base;
                        rd_addr_d  = cfg_base;
                        rd_en_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (rd_en_q && issue_last) begin
                    state_d = DRAIN;
                end else begin
                    if (rd_en_q) begin
                        if (issue_row_last) begin
                            col_d      = '0;
                            row_d      = row_q + DIM_W'(1);
                            row_base_d = row_base_q + stride_q;
                        end else begin
                            col_d = col_q + DIM_W'(1);
                        end
                        rd_addr_d = row_base_d + ADDR_W'(col_d);
                    end
                    rd_en_d = (credit_d < CNT_W'(FIFO_DEPTH));
                end
            end
            DRAIN: begin
                if (pop && head.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            stride_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            credit_q   <= '0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            stride_q   <= stride_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            credit_q   <= credit_d;
        end
    end

    // Read-return tracker: tags each request so its data lands in the FIFO RD_LAT cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q  <= '0;
            pipe_rl_q   <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q  <= RD_LAT'({pipe_vld_q, rd_en_q});
            pipe_rl_q   <= RD_LAT'({pipe_rl_q, rd_en_q && issue_row_last});
            pipe_last_q <= RD_LAT'({pipe_last_q, rd_en_q && issue_last});
        end
    end

    assign push_beat.data     = rd_data;
    assign push_beat.row_last = pipe_rl_q[RD_LAT-1];
    assign push_beat.last     = pipe_last_q[RD_LAT-1];

    fetch_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pipe_vld_q[RD_LAT-1]),
        .push_beat_i (push_beat),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Credits cover everything stored plus everything still in flight.
    assert property (@(posedge clk) disable iff (rst) credit_q >= fifo_count);
    assert property (@(posedge clk) disable iff (rst) fifo_full |-> (credit_q == CNT_W'(FIFO_DEPTH)));

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign out_valid    = !fifo_empty;
    assign out_data     = head.data;
    assign out_row_last = !fifo_empty && head.row_last;
    assign out_last     = !fifo_empty && head.last;

endmodule

// File: tb/tb_tile_fetch_stream.sv
// Bench for tile_fetch_stream: memory model, tile-level expectation model and directed tests.
module tb_tile_fetch_stream;
    import tile_fetch_pkg::*;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LANES  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DIM_W  = 10;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned BW     = DATA_W * LANES;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              rl;
        logic              l;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst, start, out_ready;
    logic [ADDR_W-1:0] cfg_base, cfg_stride;
    logic [DIM_W-1:0]  cfg_rows, cfg_cols;
    logic              busy, done, err, rd_en, out_valid, out_row_last, out_last;
    logic [ADDR_W-1:0] rd_addr;
    logic [BW-1:0]     rd_data, out_data;

    int total = 0;
    int bad   = 0;
    int cyc = 0, n_beats = 0, n_addr = 0, n_done = 0, n_err = 0, n_rd = 0;
    int max_outst = 0, rise_cyc = 0;
    logic [ADDR_W-1:0] al [64];
    logic              bl_rl [64];
    logic              bl_l [64];
    int                bl_cyc [64];
    logic [DATA_W-1:0] bl_d0 [64];
    exp_t              eq [$];
    logic [ADDR_W-1:0] aq [$];

    always #5 clk = ~clk;

    tile_fetch_stream #(
        .DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .DIM_W(DIM_W),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_rows(cfg_rows),
        .cfg_cols(cfg_cols), .cfg_stride(cfg_stride), .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row_last(out_row_last),
        .out_last(out_last)
    );

    // Memory contents: lane i of word a holds the element index a*LANES+i.
    function automatic logic [BW-1:0] word_of(input logic [ADDR_W-1:0] a);
        logic [BW-1:0] w;
        for (int i = 0; i < int'(LANES); i++) begin
            w[i*DATA_W +: DATA_W] = DATA_W'(a * ADDR_W'(LANES) + ADDR_W'(i));
        end
        return w;
    endfunction

    // Fixed-latency read port; returns garbage when no read is due.
    logic [RD_LAT-1:0] mv = '0;
    logic [ADDR_W-1:0] ma [RD_LAT];
    always @(posedge clk) begin
        mv    <= {mv[RD_LAT-2:0], rd_en};
        ma[0] <= rd_addr;
        ma[1] <= ma[0];
        ma[2] <= ma[1];
    end
    assign rd_data = mv[RD_LAT-1] ? word_of(ma[RD_LAT-1]) : {LANES{16'hDEAD}};

    function automatic void chk(input bit ok, input string nm,
                                input logic [63:0] act, input logic [63:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, want);
        end
    endfunction

    // Per-cycle comparison against the tile model.
    task automatic monitor();
        logic hold, prev_busy, m_busy, m_done, m_err, nx_busy, nx_done, nx_err;
        logic [BW-1:0] hd;
        logic hrl, hl;
        int outst;
        exp_t e;
        logic [ADDR_W-1:0] a;
        hold = 1'b0; prev_busy = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        hd = '0; hrl = 1'b0; hl = 1'b0; outst = 0;
        forever begin
            @(negedge clk);
            cyc++;
            chk(busy === m_busy, "busy", 64'(busy), 64'(m_busy));
            chk(done === m_done, "done", 64'(done), 64'(m_done));
            chk(err === m_err, "err", 64'(err), 64'(m_err));
            if (hold) begin
                chk(out_valid === 1'b1 && out_data === hd && out_row_last === hrl && out_last === hl,
                    "hold_stable", 64'(out_data), 64'(hd));
            end
            if (busy === 1'b1 && !prev_busy) rise_cyc = cyc;
            prev_busy = (busy === 1'b1);
            if (done === 1'b1) n_done++;
            if (err === 1'b1) n_err++;
            nx_busy = m_busy; nx_done = 1'b0; nx_err = 1'b0;
            if (rst) begin
                eq.delete(); aq.delete();
                outst = 0; nx_busy = 1'b0; hold = 1'b0;
            end else begin
                if (rd_en === 1'b1) begin
                    n_rd++;
                    chk(outst < int'(DEPTH), "credit", 64'(outst), 64'(DEPTH - 1));
                    if (aq.size() == 0) begin
                        chk(1'b0, "spurious_rd", 64'(rd_addr), 64'(0));
                    end else begin
                        a = aq.pop_front();
                        chk(rd_addr === a, "rd_addr", 64'(rd_addr), 64'(a));
                    end
                    if (n_addr < 64) al[n_addr] = rd_addr;
                    n_addr++;
                    outst++;
                    if (outst > max_outst) max_outst = outst;
                end
                if (out_valid === 1'b1 && out_ready) begin
                    if (eq.size() == 0) begin
                        chk(1'b0, "spurious_beat", 64'(out_data), 64'(0));
                    end else begin
                        e = eq.pop_front();
                        chk(out_data === word_of(e.addr), "beat_data", 64'(out_data), 64'(word_of(e.addr)));
                        chk({out_row_last, out_last} === {e.rl, e.l}, "beat_flags",
                            64'({out_row_last, out_last}), 64'({e.rl, e.l}));
                        if (e.l) begin nx_busy = 1'b0; nx_done = 1'b1; end
                    end
                    if (n_beats < 64) begin
                        bl_rl[n_beats] = out_row_last; bl_l[n_beats] = out_last;
                        bl_cyc[n_beats] = cyc; bl_d0[n_beats] = out_data[DATA_W-1:0];
                    end
                    n_beats++;
                    outst--;
                end
                if (!m_busy && start) begin
                    if (cfg_rows == '0 || cfg_cols == '0) begin
                        nx_done = 1'b1; nx_err = 1'b1;
                    end else begin
                        nx_busy = 1'b1;
                        for (int r = 0; r < int'(cfg_rows); r++) begin
                            for (int c = 0; c < int'(cfg_cols); c++) begin
                                e.addr = cfg_base + ADDR_W'(r) * cfg_stride + ADDR_W'(c);
                                e.rl   = (c == int'(cfg_cols) - 1);
                                e.l    = e.rl && (r == int'(cfg_rows) - 1);
                                aq.push_back(e.addr);
                                eq.push_back(e);
                            end
                        end
                    end
                end
                hold = (out_valid === 1'b1) && !out_ready;
                hd = out_data; hrl = out_row_last; hl = out_last;
            end
            m_busy = nx_busy; m_done = nx_done; m_err = nx_err;
        end
    endtask

    task automatic start_tile(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                              input int rows, input int cols);
        cfg_base = base; cfg_stride = stride;
        cfg_rows = DIM_W'(rows); cfg_cols = DIM_W'(cols);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = n_done; k = 0;
        while (n_done == d0 && k < budget) begin @(negedge clk); k++; end
        if (n_done == d0) chk(1'b0, "timeout_done", 64'(k), 64'(budget));
        @(posedge clk); #1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (n_beats < n && k < budget) begin @(negedge clk); k++; end
        if (n_beats < n) chk(1'b0, "timeout_beats", 64'(n_beats), 64'(n));
    endtask

    task automatic clear_logs();
        n_beats = 0; n_addr = 0; max_outst = 0;
    endtask

    logic [ADDR_W-1:0] t1_addr [6] = '{32'h100, 32'h101, 32'h102, 32'h108, 32'h109, 32'h10A};
    logic [ADDR_W-1:0] t6_addr [4] = '{32'h500, 32'h501, 32'h520, 32'h521};
    int d0, e0, r0;

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        cfg_base = '0; cfg_stride = '0; cfg_rows = '0; cfg_cols = '0;
        @(posedge clk); #1;
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk({busy, done, err, rd_en, out_valid, out_row_last, out_last} === 7'b0, "reset_outs",
            64'({busy, done, err, rd_en, out_valid, out_row_last, out_last}), 64'(0));
        chk(rd_addr === '0 && out_data === '0, "reset_bus", 64'(rd_addr), 64'(0));

        // 1: 2x3 tile, stride 8
        clear_logs(); d0 = n_done; e0 = n_err;
        start_tile(32'h100, 32'h8, 2, 3);
        wait_done(100);
        repeat (3) @(posedge clk); #1;
        chk(n_addr == 6, "t1_nreads", 64'(n_addr), 64'(6));
        for (int i = 0; i < 6; i++) chk(al[i] === t1_addr[i], "t1_addr", 64'(al[i]), 64'(t1_addr[i]));
        chk(n_beats == 6, "t1_nbeats", 64'(n_beats), 64'(6));
        chk({bl_rl[0], bl_rl[1], bl_rl[2], bl_rl[3], bl_rl[4], bl_rl[5]} === 6'b001001,
            "t1_rowlast", 64'({bl_rl[0], bl_rl[1], bl_rl[2], bl_rl[3], bl_rl[4], bl_rl[5]}), 64'(6'b001001));
        chk(bl_l[5] === 1'b1 && bl_l[4] === 1'b0, "t1_last", 64'({bl_l[4], bl_l[5]}), 64'(1));
        chk(bl_d0[0] === 16'h0400, "t1_lane0", 64'(bl_d0[0]), 64'(16'h0400));
        chk(n_done - d0 == 1 && n_err == e0, "t1_done", 64'(n_done - d0), 64'(1));

        // 2: 4x4 tile at full rate
        clear_logs();
        start_tile(32'h200, 32'h10, 4, 4);
        wait_done(200);
        chk(n_beats == 16, "t2_nbeats", 64'(n_beats), 64'(16));
        chk(bl_cyc[0] - rise_cyc == int'(RD_LAT) + 1, "t2_latency",
            64'(bl_cyc[0] - rise_cyc), 64'(RD_LAT + 1));
        chk(bl_cyc[15] - bl_cyc[0] == 15, "t2_nobubble", 64'(bl_cyc[15] - bl_cyc[0]), 64'(15));

        // 3: same tile with a 20-cycle stall mid-stream
        clear_logs(); d0 = n_done;
        start_tile(32'h200, 32'h10, 4, 4);
        wait_beats(3, 100);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(200);
        chk(max_outst == int'(DEPTH), "t3_credit_max", 64'(max_outst), 64'(DEPTH));
        chk(n_beats == 16 && n_addr == 16, "t3_counts", 64'(n_beats), 64'(16));
        chk(n_done - d0 == 1, "t3_done", 64'(n_done - d0), 64'(1));

        // 4: zero-dimension start
        r0 = n_rd; d0 = n_done; e0 = n_err;
        start_tile(32'h700, 32'h1, 0, 5);
        chk(done === 1'b1 && err === 1'b1 && busy === 1'b0, "t4_pulse",
            64'({busy, done, err}), 64'(3'b011));
        repeat (5) @(posedge clk); #1;
        chk(n_rd == r0, "t4_no_reads", 64'(n_rd - r0), 64'(0));
        chk(n_done - d0 == 1 && n_err - e0 == 1, "t4_counts", 64'(n_done - d0), 64'(1));

        // 5: reset mid-tile, then a fresh tile
        clear_logs(); d0 = n_done;
        start_tile(32'h300, 32'h10, 4, 4);
        wait_beats(5, 100);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk(n_done == d0, "t5_no_abort_done", 64'(n_done - d0), 64'(0));
        chk(busy === 1'b0 && out_valid === 1'b0, "t5_idle", 64'({busy, out_valid}), 64'(0));
        clear_logs();
        start_tile(32'h40, 32'h4, 4, 4);
        wait_done(200);
        chk(n_beats == 16, "t5_nbeats", 64'(n_beats), 64'(16));
        chk(bl_d0[0] === 16'h0100, "t5_first", 64'(bl_d0[0]), 64'(16'h0100));

        // 6: start re-asserted while busy
        clear_logs(); d0 = n_done;
        start_tile(32'h500, 32'h20, 2, 2);
        cfg_base = 32'h900; cfg_stride = 32'h3; cfg_rows = 10'd3; cfg_cols = 10'd3;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_done(100);
        repeat (5) @(posedge clk); #1;
        chk(n_addr == 4 && n_beats == 4, "t6_counts", 64'(n_addr), 64'(4));
        for (int i = 0; i < 4; i++) chk(al[i] === t6_addr[i], "t6_addr", 64'(al[i]), 64'(t6_addr[i]));
        chk(n_done - d0 == 1, "t6_one_done", 64'(n_done - d0), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_fetch_stream.md
Name: tile_fetch_stream

Overview:
Parametrised successor to the single-element tile fetcher. It streams a strided 2-D tile from a multi-lane read port directly to the systolic array, with no full-tile buffering. Each memory word carries LANES elements. Reads are pipelined at one request per cycle, with a configurable read latency. A credit-controlled skid FIFO absorbs out_ready backpressure. The block sits between the memory arbiter and the systolic-array input feeder.

Parameters:
DATA_W, 16, bits per element
LANES, 4, elements per memory word and per output beat
ADDR_W, 32, read address width (word addressed)
DIM_W, 10, width of row/column count fields
RD_LAT, 1, cycles from rd_en to rd_data valid; legal range >= 1
FIFO_DEPTH, 8, skid FIFO entries; power of 2, >= RD_LAT+2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  launch a tile; sampled in IDLE only
cfg_base  in  ADDR_W  word address of element (0,0); sampled on accepted start
cfg_rows  in  DIM_W  tile rows; sampled on accepted start
cfg_cols  in  DIM_W  words per row; sampled on accepted start
cfg_stride  in  ADDR_W  word distance between row starts; sampled on accepted start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at tile completion
err  out  1  one-cycle pulse, together with done, on a zero-dimension start
rd_en  out  1  read request, one word
rd_addr  out  ADDR_W  request address
rd_data  in  LANES*DATA_W  read data, valid exactly RD_LAT cycles after rd_en
out_valid  out  1  beat valid
out_ready  in  1  consumer accepts beat
out_data  out  LANES*DATA_W  beat; lane 0 in bits [DATA_W-1:0]
out_row_last  out  1  beat is the last word of a row
out_last  out  1  beat is the last word of the tile

Behaviour:
- Reset: state IDLE. Counters, credit count, FIFO pointers and read-valid pipeline are cleared. All outputs are 0. Reset must be honoured mid-operation: in-flight read returns are discarded, and no done is generated.
- States: IDLE, ISSUE, DRAIN.
- IDLE, start=1, cfg_rows!=0 and cfg_cols!=0: latch config, go to ISSUE.
- IDLE, start=1 with either dimension 0: done=1 and err=1 next cycle. No reads are issued. Stay in IDLE.
- start is ignored while busy.
- ISSUE:
  - Issue rd_en in a cycle when (in-flight + FIFO occupancy) < FIFO_DEPTH.
  - rd_addr = row_base + col, where row_base starts at cfg_base and advances by cfg_stride per row.
  - All address sums wrap modulo 2^ADDR_W.
  - Column counter runs 0..cfg_cols-1, then rolls over and increments the row counter.
  - After issuing the final word (row=cfg_rows-1, col=cfg_cols-1), go to DRAIN.
- Read tracking:
  - An RD_LAT-deep shift register carries {valid, row_last, last} per request.
  - When the tail is valid, push rd_data plus its flags into the FIFO.
  - The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
- Output:
  - FIFO is first-word-fall-through. out_valid = !empty; out_data and flags come from the head.
  - Pop on out_valid && out_ready.
  - out_data and flags must remain stable while out_valid && !out_ready.
- DRAIN: when the beat with out_last is accepted, pulse done the next cycle and return to IDLE. busy drops in that same cycle.
- Simultaneous push and pop with the FIFO full or empty must be handled correctly, with occupancy unchanged.
- Throughput: with out_ready held high, one beat per cycle after an initial RD_LAT+1 cycle latency from start.
- Beat count is exactly cfg_rows*cfg_cols; out_row_last is asserted on every cfg_cols-th beat.

Decomposition:
- Package tile_fetch_pkg:
  - state enum fetch_state_t {IDLE, ISSUE, DRAIN}
  - struct beat_t {data, row_last, last}
  - localparam for credit counter width, $clog2(FIFO_DEPTH+1)
- One sub-module, fetch_skid_fifo: parametrised first-word-fall-through FIFO of beat_t with push, pop, full, empty and count outputs.

Test Plan:
1. base=0x100, stride=8, rows=2, cols=3, out_ready=1 -> rd_addr sequence 0x100,0x101,0x102,0x108,0x109,0x10A; 6 beats; out_row_last on beats 3 and 6; out_last on beat 6; single done pulse; err=0.
2. rows=4, cols=4, RD_LAT=3, FIFO_DEPTH=8, out_ready=1 -> first beat 4 cycles after start, then 16 consecutive beats with no bubbles.
3. Same tile with out_ready low for 20 cycles mid-stream -> rd_en stalls once credits reach 8; data held stable; no beat lost or duplicated; order matches addresses.
4. rows=0, cols=5 -> done=1 and err=1 one cycle after start; rd_en never asserted; busy stays 0.
5. rst pulsed after 5 of 16 beats, then a new start with base=0x40 -> no done from the aborted tile; the new tile streams only data from 0x40 onward, with no stale beats.
6. start re-asserted while busy with different config -> ignored; addresses follow the original config; exactly one done.
